// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared Tomasulo CDB types and sizing constants
package cdb_arbiter_pkg;

    localparam int NUM_FU  = 4;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 3;
    localparam int FU_ID_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    typedef logic [TAG_W-1:0]   rob_tag_t;
    typedef logic [FU_ID_W-1:0] fu_id_t;

    // One CDB broadcast as seen by reservation stations, ALUs and the ROB.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        rob_tag_t          tag;
        logic              req;
    } cdb_data_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - functional-unit result handshake and CDB broadcast bundle
interface cdb_arbiter_if #(
    parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int TAG_W  = cdb_arbiter_pkg::TAG_W
);

    logic [NUM_FU-1:0]             fu_valid;
    logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
    logic [NUM_FU-1:0][TAG_W-1:0]  fu_tag;
    logic [NUM_FU-1:0]             fu_ready;
    logic                          cdb_valid;
    logic [DATA_W-1:0]             cdb_data;
    logic [TAG_W-1:0]              cdb_tag;
    logic [NUM_FU-1:0]             cdb_grant;

    // Functional-unit side: produces results, observes the broadcast.
    modport master (
        output fu_valid, fu_data, fu_tag,
        input  fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_grant
    );

    // Arbiter side.
    modport slave (
        input  fu_valid, fu_data, fu_tag,
        output fu_ready, cdb_valid, cdb_data, cdb_tag, cdb_grant
    );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rtl/cdb_arbiter_rr_arbiter.sv - combinational rotating-priority one-hot picker
module rr_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = NUM_FU,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant
);

    logic          found;
    logic [PW-1:0] idx;
    int            pos;

    // Scan from ptr upward, wrapping, and grant the first requester seen.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = (int'(ptr) + i) % N;
            idx = PW'(pos);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - per-unit result buffers shared round-robin onto the CDB
module cdb_arbiter #(
    parameter int NUM_FU = cdb_arbiter_pkg::NUM_FU,
    parameter int DATA_W = cdb_arbiter_pkg::DATA_W,
    parameter int TAG_W  = cdb_arbiter_pkg::TAG_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    cdb_arbiter_if.slave bus
);

    localparam int PW = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

    logic [NUM_FU-1:0]             occ;
    logic [NUM_FU-1:0][DATA_W-1:0] data_q;
    logic [NUM_FU-1:0][TAG_W-1:0]  tag_q;
    logic [PW-1:0]                 rr_ptr;

    logic [NUM_FU-1:0] grant_raw;
    logic [NUM_FU-1:0] accept;
    logic [PW-1:0]     winner;
    logic [PW-1:0]     ptr_next;
    logic              any_occ;
    logic [DATA_W-1:0] mux_data;
    logic [TAG_W-1:0]  mux_tag;

    rr_arbiter #(.N(NUM_FU), .PW(PW)) u_pick (
        .req   (occ),
        .ptr   (rr_ptr),
        .grant (grant_raw)
    );

    // Outputs come only from registered buffers plus flush; fu_valid never reaches the CDB.
    assign any_occ       = |occ;
    assign bus.cdb_valid = any_occ & ~flush;
    assign bus.cdb_grant = flush ? '0 : grant_raw;
    assign bus.fu_ready  = ~occ | bus.cdb_grant;
    assign bus.cdb_data  = mux_data;
    assign bus.cdb_tag   = mux_tag;
    assign accept        = bus.fu_valid & bus.fu_ready;
    assign ptr_next      = (winner == PW'(NUM_FU - 1)) ? '0 : winner + 1'b1;

    // Select the winning buffer's payload and encode its index for the pointer update.
    always_comb begin
        mux_data = '0;
        mux_tag  = '0;
        winner   = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            if (grant_raw[i]) begin
                mux_data = mux_data | data_q[i];
                mux_tag  = mux_tag | tag_q[i];
                winner   = PW'(i);
            end
        end
    end

    // Buffer fill/drain and round-robin pointer; a broadcast buffer may refill in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ    <= '0;
            data_q <= '0;
            tag_q  <= '0;
            rr_ptr <= '0;
        end else if (flush) begin
            occ <= '0;
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    occ[i]    <= 1'b1;
                    data_q[i] <= bus.fu_data[i];
                    tag_q[i]  <= bus.fu_tag[i];
                end else if (grant_raw[i]) begin
                    occ[i] <= 1'b0;
                end
            end
            if (any_occ) begin
                rr_ptr <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized check of cdb_arbiter against a buffer model
module tb_cdb_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int TW = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) bus ();

    cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_occ  [N];
    logic [DW-1:0] m_data [N];
    logic [TW-1:0] m_tag  [N];
    int          m_ptr;

    logic          obs_valid;
    logic [N-1:0]  obs_grant;
    logic [N-1:0]  obs_ready;
    logic [DW-1:0] obs_data;
    logic [TW-1:0] obs_tag;
    logic [N-1:0]  last_ready;

    logic [N-1:0][DW-1:0] d;
    logic [N-1:0][TW-1:0] t;
    logic [N-1:0]         v;

    bit          p_v [N];
    logic [DW-1:0] p_d [N];
    logic [TW-1:0] p_t [N];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_occ[k]  = 1'b0;
            m_data[k] = '0;
            m_tag[k]  = '0;
        end
        m_ptr = 0;
    endtask

    // One clock cycle: apply inputs, predict and compare outputs, then advance the model.
    task automatic step(input logic [N-1:0] sv, input logic [N-1:0][DW-1:0] sd,
                        input logic [N-1:0][TW-1:0] st, input logic fl);
        int           w;
        int           j;
        logic         ev;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        bus.fu_valid = sv;
        bus.fu_data  = sd;
        bus.fu_tag   = st;
        flush        = fl;
        #1;
        w = -1;
        for (int k = 0; k < N; k++) begin
            j = (m_ptr + k) % N;
            if (w < 0 && m_occ[j]) w = j;
        end
        ev = (w >= 0) && !fl;
        eg = '0;
        if (ev) eg[w] = 1'b1;
        for (int k = 0; k < N; k++) er[k] = !m_occ[k] || eg[k];
        last_ready = er;
        obs_valid  = bus.cdb_valid;
        obs_grant  = bus.cdb_grant;
        obs_ready  = bus.fu_ready;
        obs_data   = bus.cdb_data;
        obs_tag    = bus.cdb_tag;
        check("cdb_valid", obs_valid, ev);
        check("cdb_grant", obs_grant, eg);
        check("fu_ready", obs_ready, er);
        if (ev) begin
            check("cdb_data", obs_data, m_data[w]);
            check("cdb_tag", obs_tag, m_tag[w]);
        end
        @(posedge clk);
        if (fl) begin
            for (int k = 0; k < N; k++) m_occ[k] = 1'b0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (sv[k] && er[k]) begin
                    m_occ[k]  = 1'b1;
                    m_data[k] = sd[k];
                    m_tag[k]  = st[k];
                end else if (eg[k]) begin
                    m_occ[k] = 1'b0;
                end
            end
            if (w >= 0) m_ptr = (w + 1) % N;
        end
        #1;
    endtask

    task automatic idle_step();
        logic [N-1:0][DW-1:0] zd;
        logic [N-1:0][TW-1:0] zt;
        zd = '0;
        zt = '0;
        step('0, zd, zt, 1'b0);
    endtask

    // Drop reset between edges and verify outputs react without a clock.
    task automatic async_reset();
        bus.fu_valid = '0;
        flush = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", bus.cdb_valid, 1'b0);
        check("arst_grant", bus.cdb_grant, '0);
        check("arst_ready", bus.fu_ready, 4'b1111);
        check("arst_tag", bus.cdb_tag, '0);
        check("arst_data", bus.cdb_data, '0);
        model_reset();
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_g;
        bus.fu_valid = '0;
        bus.fu_data  = '0;
        bus.fu_tag   = '0;
        model_reset();
        #3;
        check("rst_valid", bus.cdb_valid, 1'b0);
        check("rst_data", bus.cdb_data, '0);
        check("rst_tag", bus.cdb_tag, '0);
        check("rst_grant", bus.cdb_grant, '0);
        check("rst_ready", bus.fu_ready, 4'b1111);
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int k = 0; k < 5; k++) idle_step();
        check("idle_valid", obs_valid, 1'b0);
        check("idle_ready", obs_ready, 4'b1111);

        // Single result from unit 2.
        d = '0; t = '0;
        d[2] = 32'hDEADBEEF;
        t[2] = 3'd5;
        step(4'b0100, d, t, 1'b0);
        idle_step();
        check("single_valid", obs_valid, 1'b1);
        check("single_tag", obs_tag, 3'd5);
        check("single_data", obs_data, 32'hDEADBEEF);
        check("single_grant", obs_grant, 4'b0100);
        idle_step();
        check("single_after", obs_valid, 1'b0);

        // Full contention from rr_ptr = 0.
        async_reset();
        for (int k = 0; k < 9; k++) begin
            for (int u = 0; u < N; u++) begin
                d[u] = $urandom;
                t[u] = TW'(u);
            end
            step(4'b1111, d, t, 1'b0);
            if (k >= 1) begin
                exp_g = 4'b0001 << ((k - 1) % N);
                check("contention_grant", obs_grant, exp_g);
                check("contention_tag", obs_tag, (k - 1) % N);
            end
        end

        // Flush with three occupied buffers and unit 3 presenting.
        async_reset();
        d = '0; t = '0;
        for (int u = 0; u < 3; u++) begin
            d[u] = $urandom;
            t[u] = TW'(u + 1);
        end
        step(4'b0111, d, t, 1'b0);
        d = '0; t = '0;
        d[3] = 32'h0BAD_F00D;
        t[3] = 3'd7;
        step(4'b1000, d, t, 1'b1);
        check("flush_valid", obs_valid, 1'b0);
        check("flush_grant", obs_grant, '0);
        for (int k = 0; k < 4; k++) begin
            idle_step();
            check("flush_drop", obs_valid, 1'b0);
        end

        // Back-pressure: unit 1 must wait while unit 0 broadcasts.
        async_reset();
        d = '0; t = '0;
        d[0] = 32'h1111_0000; t[0] = 3'd2;
        d[1] = 32'h2222_0006; t[1] = 3'd6;
        step(4'b0011, d, t, 1'b0);
        step(4'b0010, d, t, 1'b0);
        check("bp_ready1", obs_ready[1], 1'b0);
        check("bp_grant0", obs_grant, 4'b0001);
        idle_step();
        check("bp_grant1", obs_grant, 4'b0010);
        check("bp_tag1", obs_tag, 3'd6);
        check("bp_data1", obs_data, 32'h2222_0006);

        // Randomized traffic; units hold a result until it is accepted.
        async_reset();
        for (int u = 0; u < N; u++) p_v[u] = 1'b0;
        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!p_v[u] && $urandom_range(0, 99) < 45) begin
                    p_v[u] = 1'b1;
                    p_d[u] = $urandom;
                    p_t[u] = TW'($urandom_range(0, 7));
                end
                v[u] = p_v[u];
                d[u] = p_d[u];
                t[u] = p_t[u];
            end
            step(v, d, t, $urandom_range(0, 29) == 0);
            for (int u = 0; u < N; u++) begin
                if (p_v[u] && last_ready[u]) p_v[u] = 1'b0;
            end
            if ($urandom_range(0, 149) == 0) begin
                async_reset();
                for (int u = 0; u < N; u++) p_v[u] = 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Round-robin arbiter sharing the single common data bus (CDB) among the Tomasulo functional units (ALU instances, load unit, branch unit). Each unit writes a finished result into a one-entry holding buffer inside this block; the arbiter broadcasts at most one buffered result per cycle as tag plus data to the reservation stations and ROB. It also back-pressures units whose buffer is still waiting, and drops all pending results on a pipeline flush.

## Interface
- NUM_FU, 4, number of requesting functional units (2..8)
- DATA_W, 32, result width
- TAG_W, 3, ROB tag width
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush from ROB (mispredict); drops all buffered results
- fu_valid  in  NUM_FU  unit i presents a result this cycle
- fu_data  in  NUM_FU×DATA_W  result value per unit
- fu_tag  in  NUM_FU×TAG_W  destination ROB tag per unit
- fu_ready  out  NUM_FU  unit i's buffer can accept this cycle
- cdb_valid  out  1  broadcast valid (drives cdb_data.req)
- cdb_data  out  DATA_W  broadcast value
- cdb_tag  out  TAG_W  broadcast ROB tag
- cdb_grant  out  NUM_FU  one-hot, unit whose buffer is broadcast this cycle

## Operation
- Per unit i: buffer {occ, data, tag}. Accept = fu_valid[i] & fu_ready[i]; on accept, buffer loads at the clock edge, occ=1.
- fu_ready[i] = !occ[i] | cdb_grant[i]. A buffer being broadcast can refill in the same cycle, so a unit that wins every cycle sustains one result per cycle.
- Arbitration is combinational over occ[]. The search starts at rr_ptr and wraps modulo NUM_FU; the first occupied index wins.
- cdb_valid = any occ; cdb_data/cdb_tag are muxed from the winner's buffer; cdb_grant is the one-hot winner, all zero when nothing is occupied.
- At the edge, the winner's occ clears unless it is refilled. rr_ptr becomes (winner+1) mod NUM_FU and is unchanged when idle.
- fu_valid while !fu_ready: the block ignores it. The unit must hold its result (unit-side contract).
- flush=1: all occ clear at the edge and incoming accepts that cycle are discarded. cdb_valid is forced 0 and cdb_grant to 0 during the flush cycle. rr_ptr is unchanged.
- Reset (rst low, asynchronous): occ all 0, rr_ptr=0, and data/tag registers go to 0.
- Reset-state outputs: cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_grant=0, fu_ready all 1.
- Reset mid-operation discards pending results without broadcasting them.

## Timing
- Latency: a result accepted at edge t is on the CDB no earlier than the cycle after edge t (one cycle minimum). Worst case is NUM_FU cycles under full contention.
- Fairness: a waiting unit is granted within NUM_FU cycles of becoming occupied.
- Outputs are combinational from registered state (occ, data, tag, rr_ptr) and flush only. There is no combinational path from fu_valid/fu_data to the CDB outputs.
- fu_ready depends only on registered state; it does not depend on fu_valid.
- Simultaneous flush and accept: flush wins.
- Simultaneous grant and refill of the same unit: the new result is retained and occ stays 1.

## Structure
- tomasula_types package additions:
  - NUM_FU localparam
  - rob_tag_t typedef
  - cdb_data struct {data, tag, req}, reused by alu, reservation stations and ROB
  - fu_id_t typedef
- Sub-module rr_arbiter: parameterised combinational rotating-priority picker. Inputs are request vector and pointer; output is one-hot grant. Tested standalone.
- Top level holds the buffers, rr_ptr and the output mux.

## Test plan
- Reset then idle:
  - Response: cdb_valid=0, fu_ready=4'b1111, cdb_grant=0.
  - Release rst, drive nothing for 5 cycles; outputs stay the same.
- Single result:
  - Stimulus: unit 2 drives tag 5, data 0xDEADBEEF at edge t.
  - Response: in the next cycle, cdb_valid=1, tag=5, data=0xDEADBEEF, grant=4'b0100. The cycle after, cdb_valid=0.
- Full contention:
  - Stimulus: all 4 units present tags 0..3 on the same edge, then keep presenting every cycle.
  - Response: grants go 0,1,2,3,0,… with one broadcast per cycle and no unit starved.
- Back-pressure:
  - Stimulus: units 0 and 1 both occupied, rr_ptr=0.
  - Response: fu_ready[1]=0 while unit 0 broadcasts. Unit 1's held result, tag 6, appears the next cycle unchanged.
- Flush:
  - Stimulus: 3 buffers occupied, assert flush for one cycle with unit 3 also presenting.
  - Response: cdb_valid=0 that cycle, all buffers empty after the edge, and unit 3's result is never broadcast.
- Async reset mid-stream:
  - Stimulus: drop rst between edges while buffers are occupied.
  - Response: cdb_valid goes to 0 immediately, without waiting for a clock edge, and no stale tag is broadcast after release.
